branch_resolve_ctrl: RTL and testbench

- Fetch-redirect and branch-resolution controller sitting between the fetch PC register, branch_predictor, DECODE and EXEC.
- Owns the fetch PC and records each decoded branch together with its prediction in an in-order pending queue.
- Compares each EXEC resolution against the recorded prediction, drives predictor training, and on a mispredict redirects fetch and flushes the front end.

---
 rtl/bp_pkg.sv | 28 ++
 rtl/bp_pending_fifo.sv | 82 ++++++++
 rtl/branch_resolve_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pkg
//  Brief    : Shared types and constants for the branch resolution slice.
//  Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int ADDR_W      = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_target;
    } bp_entry_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bp_state_t;

    function automatic logic [ADDR_W-1:0] seq_pc(input logic [ADDR_W-1:0] pc);
        return pc + ADDR_W'(INSTR_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_pending_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : bp_pending_fifo
//  Brief    : In-order synchronous FIFO of pending branch entries with clear.
//  Revision : 1.0 - initial release
// ============================================================================
module bp_pending_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_clear,
    input  bp_entry_t                  i_data,
    output bp_entry_t                  o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] C_CNT_DEPTH = (PTR_W+1)'(DEPTH);

    bp_entry_t          r_mem_q [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr_q, w_wr_ptr_d;
    logic [PTR_W-1:0]   r_rd_ptr_q, w_rd_ptr_d;
    logic [PTR_W:0]     r_count_q,  w_count_d;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count_q == C_CNT_DEPTH);
    assign o_empty   = (r_count_q == '0);
    assign o_count   = r_count_q;
    assign o_data    = r_mem_q[r_rd_ptr_q];

    // A write into a full FIFO is legal only when the head leaves the same cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_clear) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (w_do_push) w_wr_ptr_d = r_wr_ptr_q + PTR_W'(1);
            if (w_do_pop)  w_rd_ptr_d = r_rd_ptr_q + PTR_W'(1);
            unique case ({w_do_push, w_do_pop})
                2'b10:   w_count_d = r_count_q + C_CNT_ONE;
                2'b01:   w_count_d = r_count_q - C_CNT_ONE;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_clear && w_do_push) begin
            r_mem_q[r_wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_ctrl
//  Brief    : Fetch PC owner, pending-branch tracking, mispredict redirect.
//             Optional macro BRANCH_STATS_EN adds saturating branch counters.
//  Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_1000,
    parameter int          DEPTH        = 4,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     f_predict_valid,
    input  logic [31:0]              f_predict_addr,
    output logic [31:0]              f_pc,
    input  logic                     d_valid,
    input  logic                     d_is_branch,
    input  logic [31:0]              d_pc,
    input  logic                     d_pred_taken,
    input  logic [31:0]              d_pred_target,
    output logic                     d_stall,
    input  logic                     x_resolve,
    input  logic                     x_taken,
    input  logic [31:0]              x_target,
    output logic                     flush,
    output logic                     upd_valid,
    output logic [31:0]              upd_pc,
    output logic [31:0]              upd_target,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   pending_cnt,
    output logic                     protocol_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]              stat_branches,
    output logic [31:0]              stat_mispredicts
`endif
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    bp_state_t          r_state_q,     w_state_d;
    logic [CNT_W-1:0]   r_flush_cnt_q, w_flush_cnt_d;
    logic [31:0]        r_f_pc_q,      w_f_pc_d;
    logic               r_flush_q,     w_flush_d;
    logic               r_upd_valid_q, w_upd_valid_d;
    logic [31:0]        r_upd_pc_q,    w_upd_pc_d;
    logic [31:0]        r_upd_tgt_q,   w_upd_tgt_d;
    logic               r_upd_tkn_q,   w_upd_tkn_d;
    logic               r_perr_q,      w_perr_d;

    bp_entry_t          w_head;
    bp_entry_t          w_push_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_run;
    logic               w_pop;
    logic               w_push;
    logic               w_mispred;
    logic               w_clear;

    assign w_run        = (r_state_q == RUN);
    assign w_pop        = w_run && x_resolve && !w_empty;
    assign w_push       = w_run && d_valid && d_is_branch;
    assign w_mispred    = (x_taken != w_head.pred_taken) ||
                          (x_taken && (x_target != w_head.pred_target));
    assign w_clear      = w_pop && w_mispred;
    assign w_push_entry = '{pc: d_pc, pred_taken: d_pred_taken, pred_target: d_pred_target};

    assign d_stall      = w_full && d_valid && d_is_branch;

    bp_pending_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (pending_cnt)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_flush_cnt_d = r_flush_cnt_q;
        w_f_pc_d      = r_f_pc_q;
        w_upd_valid_d = w_pop;
        w_upd_pc_d    = r_upd_pc_q;
        w_upd_tgt_d   = r_upd_tgt_q;
        w_upd_tkn_d   = r_upd_tkn_q;
        w_perr_d      = w_run && x_resolve && w_empty;

        if (!stall) begin
            w_f_pc_d = f_predict_valid ? f_predict_addr : seq_pc(r_f_pc_q);
        end

        if (w_pop) begin
            w_upd_pc_d  = w_head.pc;
            w_upd_tgt_d = x_target;
            w_upd_tkn_d = x_taken;
        end

        unique case (r_state_q)
            RUN: begin
                if (w_clear) begin
                    w_state_d     = RECOVER;
                    w_flush_cnt_d = C_FLUSH_LOAD;
                    w_f_pc_d      = x_taken ? x_target : seq_pc(w_head.pc);
                end
            end
            RECOVER: begin
                if (r_flush_cnt_q <= C_CNT_ONE) begin
                    w_state_d     = RUN;
                    w_flush_cnt_d = '0;
                end else begin
                    w_flush_cnt_d = r_flush_cnt_q - C_CNT_ONE;
                end
            end
            default: begin
                w_state_d     = RUN;
                w_flush_cnt_d = '0;
            end
        endcase

        w_flush_d = (w_state_d == RECOVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= RUN;
            r_flush_cnt_q <= '0;
            r_f_pc_q      <= RESET_PC;
            r_flush_q     <= 1'b0;
            r_upd_valid_q <= 1'b0;
            r_upd_pc_q    <= '0;
            r_upd_tgt_q   <= '0;
            r_upd_tkn_q   <= 1'b0;
            r_perr_q      <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_flush_cnt_q <= w_flush_cnt_d;
            r_f_pc_q      <= w_f_pc_d;
            r_flush_q     <= w_flush_d;
            r_upd_valid_q <= w_upd_valid_d;
            r_upd_pc_q    <= w_upd_pc_d;
            r_upd_tgt_q   <= w_upd_tgt_d;
            r_upd_tkn_q   <= w_upd_tkn_d;
            r_perr_q      <= w_perr_d;
        end
    end

    assign f_pc         = r_f_pc_q;
    assign flush        = r_flush_q;
    assign upd_valid    = r_upd_valid_q;
    assign upd_pc       = r_upd_pc_q;
    assign upd_target   = r_upd_tgt_q;
    assign upd_taken    = r_upd_tkn_q;
    assign protocol_err = r_perr_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_br_q, w_stat_br_d;
    logic [31:0] r_stat_mp_q, w_stat_mp_d;

    always_comb begin
        w_stat_br_d = r_stat_br_q;
        w_stat_mp_d = r_stat_mp_q;
        if (w_pop && (r_stat_br_q != '1)) w_stat_br_d = r_stat_br_q + 32'd1;
        if (w_clear && (r_stat_mp_q != '1)) w_stat_mp_d = r_stat_mp_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br_q <= '0;
            r_stat_mp_q <= '0;
        end else begin
            r_stat_br_q <= w_stat_br_d;
            r_stat_mp_q <= w_stat_mp_d;
        end
    end

    assign stat_branches    = r_stat_br_q;
    assign stat_mispredicts = r_stat_mp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_ctrl
//  Brief    : Directed self-checking bench with an update scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        f_predict_valid;
    logic [31:0] f_predict_addr;
    logic [31:0] f_pc;
    logic        d_valid;
    logic        d_is_branch;
    logic [31:0] d_pc;
    logic        d_pred_taken;
    logic [31:0] d_pred_target;
    logic        d_stall;
    logic        x_resolve;
    logic        x_taken;
    logic [31:0] x_target;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [2:0]  pending_cnt;
    logic        protocol_err;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    branch_resolve_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .f_predict_valid (f_predict_valid),
        .f_predict_addr  (f_predict_addr),
        .f_pc            (f_pc),
        .d_valid         (d_valid),
        .d_is_branch     (d_is_branch),
        .d_pc            (d_pc),
        .d_pred_taken    (d_pred_taken),
        .d_pred_target   (d_pred_target),
        .d_stall         (d_stall),
        .x_resolve       (x_resolve),
        .x_taken         (x_taken),
        .x_target        (x_target),
        .flush           (flush),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_target      (upd_target),
        .upd_taken       (upd_taken),
        .pending_cnt     (pending_cnt),
        .protocol_err    (protocol_err)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then retire any predictor update against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (upd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("upd_unexpected", {31'd0, upd_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("upd_pc",     upd_pc,              e.pc);
                chk("upd_taken",  {31'd0, upd_taken},  {31'd0, e.taken});
                chk("upd_target", upd_target,          e.target);
            end
        end
    endtask

    task automatic set_dec(input logic v, input logic [31:0] pc,
                           input logic pt, input logic [31:0] tgt);
        d_valid       = v;
        d_is_branch   = v;
        d_pc          = pc;
        d_pred_taken  = pt;
        d_pred_target = tgt;
    endtask

    task automatic set_res(input logic v, input logic t, input logic [31:0] tgt);
        x_resolve = v;
        x_taken   = t;
        x_target  = tgt;
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        exp_t e;
        e.pc = pc; e.taken = t; e.target = tgt;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0;
        f_predict_valid = 1'b0; f_predict_addr = '0;
        set_dec(1'b0, '0, 1'b0, '0);
        set_res(1'b0, 1'b0, '0);
        step();
        step();
        chk("rst_fpc",     f_pc, 32'h1000);
        chk("rst_flush",   {31'd0, flush}, 32'd0);
        chk("rst_pending", {29'd0, pending_cnt}, 32'd0);
        chk("rst_upd",     {31'd0, upd_valid}, 32'd0);
        chk("rst_perr",    {31'd0, protocol_err}, 32'd0);
        rst = 1'b0;
        chk("seq_fpc0", f_pc, 32'h1000);
        step(); chk("seq_fpc1", f_pc, 32'h1004);
        step(); chk("seq_fpc2", f_pc, 32'h1008);
        step(); chk("seq_fpc3", f_pc, 32'h100c);
        chk("seq_flush", {31'd0, flush}, 32'd0);

        // correctly predicted taken branch
        set_dec(1'b1, 32'h1008, 1'b1, 32'h1010);
        step(); chk("t2_pending", {29'd0, pending_cnt}, 32'd1);
        set_dec(1'b0, '0, 1'b0, '0);
        set_res(1'b1, 1'b1, 32'h1010);
        expect_upd(32'h1008, 1'b1, 32'h1010);
        step();
        chk("t2_updv",    {31'd0, upd_valid}, 32'd1);
        chk("t2_flush",   {31'd0, flush}, 32'd0);
        chk("t2_pending", {29'd0, pending_cnt}, 32'd0);
        set_res(1'b0, 1'b0, '0);
        step(); chk("t2_updv_off", {31'd0, upd_valid}, 32'd0);

        // predictor hit and stall hold
        f_predict_valid = 1'b1; f_predict_addr = 32'h2000;
        step(); chk("pred_fpc", f_pc, 32'h2000);
        stall = 1'b1; f_predict_addr = 32'h3000;
        step(); chk("stall_fpc", f_pc, 32'h2000);
        stall = 1'b0; f_predict_valid = 1'b0;
        step(); chk("unstall_fpc", f_pc, 32'h2004);

        // predicted not-taken, actually taken
        set_dec(1'b1, 32'h100c, 1'b0, 32'h0);
        step();
        set_dec(1'b0, '0, 1'b0, '0);
        set_res(1'b1, 1'b1, 32'h1014);
        expect_upd(32'h100c, 1'b1, 32'h1014);
        step();
        chk("t3_fpc",     f_pc, 32'h1014);
        chk("t3_flush1",  {31'd0, flush}, 32'd1);
        chk("t3_pending", {29'd0, pending_cnt}, 32'd0);
        set_dec(1'b1, 32'h2222, 1'b0, 32'h0);
        set_res(1'b1, 1'b0, 32'h0);
        step();
        chk("t3_flush2",  {31'd0, flush}, 32'd1);
        chk("t3_fpc2",    f_pc, 32'h1018);
        chk("rec_perr",   {31'd0, protocol_err}, 32'd0);
        chk("rec_nopush", {29'd0, pending_cnt}, 32'd0);
        set_dec(1'b0, '0, 1'b0, '0);
        set_res(1'b0, 1'b0, '0);
        step();
        chk("t3_flush3",  {31'd0, flush}, 32'd0);
        chk("t3_fpc3",    f_pc, 32'h101c);

        // predicted taken, actually not taken, with same-cycle push and stall
        set_dec(1'b1, 32'h1014, 1'b1, 32'h1000);
        step(); chk("t4_pending", {29'd0, pending_cnt}, 32'd1);
        set_dec(1'b1, 32'h1020, 1'b0, 32'h0);
        set_res(1'b1, 1'b0, 32'h1234);
        stall = 1'b1;
        expect_upd(32'h1014, 1'b0, 32'h1234);
        step();
        chk("t4_fpc",     f_pc, 32'h1018);
        chk("t4_flush",   {31'd0, flush}, 32'd1);
        chk("t4_discard", {29'd0, pending_cnt}, 32'd0);
        set_dec(1'b0, '0, 1'b0, '0);
        set_res(1'b0, 1'b0, '0);
        stall = 1'b0;
        step();
        step();
        chk("t4_flush_end", {31'd0, flush}, 32'd0);
        chk("t4_pending2",  {29'd0, pending_cnt}, 32'd0);

        // fill the queue
        for (int i = 0; i < 4; i++) begin
            set_dec(1'b1, 32'h3000 + 32'(4 * i), 1'b0, 32'h0);
            chk("fill_nostall", {31'd0, d_stall}, 32'd0);
            step();
        end
        chk("fill_cnt", {29'd0, pending_cnt}, 32'd4);
        set_dec(1'b1, 32'h3010, 1'b0, 32'h0);
        #1;
        chk("fill_dstall", {31'd0, d_stall}, 32'd1);
        step();
        chk("fill_cnt5", {29'd0, pending_cnt}, 32'd4);
        set_res(1'b1, 1'b0, 32'h0);
        expect_upd(32'h3000, 1'b0, 32'h0);
        #1;
        chk("pp_dstall", {31'd0, d_stall}, 32'd1);
        step();
        chk("pp_cnt",   {29'd0, pending_cnt}, 32'd4);
        chk("pp_flush", {31'd0, flush}, 32'd0);
        set_dec(1'b0, '0, 1'b0, '0);
        for (int i = 1; i <= 4; i++) begin
            expect_upd(32'h3000 + 32'(4 * i), 1'b0, 32'h0);
            step();
            chk("drain_cnt", {29'd0, pending_cnt}, 32'(4 - i));
        end
        set_res(1'b0, 1'b0, '0);
        step();
        chk("drain_sb", 32'(exp_q.size()), 32'd0);

        // resolve on an empty queue
        set_res(1'b1, 1'b1, 32'h5555);
        step();
        chk("perr_pulse", {31'd0, protocol_err}, 32'd1);
        chk("perr_noupd", {31'd0, upd_valid}, 32'd0);
        set_res(1'b0, 1'b0, '0);
        step();
        chk("perr_clear", {31'd0, protocol_err}, 32'd0);

        // reset while recovering
        set_dec(1'b1, 32'h4000, 1'b0, 32'h0);
        step();
        set_dec(1'b0, '0, 1'b0, '0);
        set_res(1'b1, 1'b1, 32'h5000);
        expect_upd(32'h4000, 1'b1, 32'h5000);
        step();
        chk("t6_fpc",   f_pc, 32'h5000);
        chk("t6_flush", {31'd0, flush}, 32'd1);
        set_res(1'b0, 1'b0, '0);
        rst = 1'b1;
        step();
        chk("t6_rst_fpc",   f_pc, 32'h1000);
        chk("t6_rst_flush", {31'd0, flush}, 32'd0);
        chk("t6_rst_cnt",   {29'd0, pending_cnt}, 32'd0);
        rst = 1'b0;
        step();
        chk("t6_run_fpc",   f_pc, 32'h1004);
        chk("t6_run_flush", {31'd0, flush}, 32'd0);
        chk("final_sb",     32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
